scaled_addr_gen: RTL

- Next-generation VGA-to-framebuffer address generator.
- Maps the 640x480 scan position (h_cnt, v_cnt) onto an IMG_W x IMG_H block-RAM image.
- Supports run-time power-of-two scaling, pan offsets and CLAMP/WRAP/BORDER edge modes.
- Address arithmetic is incremental (per-pixel and per-line trackers): no per-pixel multiply or divide.
- Sits between the vga_controller counters and the image BRAM read port; runs in lock-step with the pixel clock.

---
 rtl/scaled_addr_gen_pkg.sv | 53 +++++
 rtl/axis_tracker.sv | 75 +++++++
 rtl/scaled_addr_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/scaled_addr_gen_pkg.sv
// Shared types and constants for the scaled VGA-to-framebuffer address generator.
// The mirror field of cfg_t exists only when SCALED_ADDR_GEN_MIRROR_EN is defined.
package scaled_addr_gen_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int IMG_W_DEF    = 160;
    localparam int IMG_H_DEF    = 120;
    localparam int ADDR_W_DEF   = 17;

    localparam int CNT_W = 10;  // scan counters, pans and tracker positions
    localparam int SUB_W = 3;   // sub-pixel counter, enough for scale_log2 = 3

    typedef enum logic [1:0] {
        MODE_CLAMP     = 2'd0,
        MODE_WRAP      = 2'd1,
        MODE_BORDER    = 2'd2,
        MODE_CLAMP_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]       scale_log2;
        mode_e            mode;
        logic [CNT_W-1:0] pan_x;
        logic [CNT_W-1:0] pan_y;
`ifdef SCALED_ADDR_GEN_MIRROR_EN
        logic             mirror;
`endif
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        scale_log2: 2'd2,
        mode:       MODE_CLAMP,
        pan_x:      '0,
        pan_y:      '0
`ifdef SCALED_ADDR_GEN_MIRROR_EN
        , mirror:   1'b0
`endif
    };

    function automatic logic [CNT_W-1:0] sat_pan(input logic [CNT_W-1:0] pan,
                                                 input logic [CNT_W-1:0] lim);
        return (pan >= lim) ? lim - CNT_W'(1) : pan;
    endfunction

endpackage

// File: rtl/axis_tracker.sv
// One scan axis: position/sub-pixel counters with wrap-or-saturate stepping and
// an optional row base that moves by STRIDE with every position increment.
module axis_tracker
    import scaled_addr_gen_pkg::*;
#(
    parameter int LIMIT  = IMG_W_DEF,
    parameter int STRIDE = 0,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [CNT_W-1:0]  i_load_pos,
    input  logic [ADDR_W-1:0] i_load_base,
    input  logic              i_step,
    input  logic [1:0]        i_scale_log2,
    input  logic              i_wrap,
    output logic [CNT_W-1:0]  o_pos,
    output logic [ADDR_W-1:0] o_base,
    output logic              o_ovf
);

    localparam logic [CNT_W-1:0]  LIMIT_C  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(LIMIT - 1);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(STRIDE);

    logic [CNT_W-1:0]  r_pos, w_pos, w_pos_nxt;
    logic [SUB_W-1:0]  r_sub, w_sub, w_sub_nxt, w_sub_max;
    logic [ADDR_W-1:0] r_base, w_base, w_base_nxt;

    // A load takes effect in the same cycle, so the consumer sees the loaded
    // value immediately and the first step starts from it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_pos      = i_load ? i_load_pos  : r_pos;
        w_sub      = i_load ? '0          : r_sub;
        w_base     = i_load ? i_load_base : r_base;
        w_sub_max  = SUB_W'((4'd1 << i_scale_log2) - 4'd1);
        w_pos_nxt  = w_pos;
        w_sub_nxt  = w_sub;
        w_base_nxt = w_base;
        if (i_step) begin
            if (w_sub != w_sub_max) begin
                w_sub_nxt = w_sub + SUB_W'(1);
            end else begin
                w_sub_nxt = '0;
                if (i_wrap && (w_pos >= LAST_C)) begin
                    w_pos_nxt  = '0;
                    w_base_nxt = '0;
                end else if (w_pos != LIMIT_C) begin
                    w_pos_nxt  = w_pos + CNT_W'(1);
                    w_base_nxt = w_base + STRIDE_C;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_pos  <= '0;
            r_sub  <= '0;
            r_base <= '0;
        end else begin
            r_pos  <= w_pos_nxt;
            r_sub  <= w_sub_nxt;
            r_base <= w_base_nxt;
        end
    end

    assign o_pos  = w_pos;
    assign o_base = w_base;
    assign o_ovf  = (w_pos == LIMIT_C);

endmodule

// File: rtl/scaled_addr_gen.sv
// Maps the VGA scan position onto an IMG_W x IMG_H BRAM image with pan, 2^n scaling and edge modes.
// Define SCALED_ADDR_GEN_MIRROR_EN to add the horizontal-mirror input.
module scaled_addr_gen
    import scaled_addr_gen_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  h_cnt,
    input  logic [CNT_W-1:0]  v_cnt,
    input  logic [1:0]        scale_log2,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  pan_x,
    input  logic [CNT_W-1:0]  pan_y,
`ifdef SCALED_ADDR_GEN_MIRROR_EN
    input  logic              mirror,
`endif
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              in_image,
    output logic              cfg_busy
);

    localparam logic [CNT_W-1:0]  SW_C       = CNT_W'(SCREEN_W);
    localparam logic [CNT_W-1:0]  SH_C       = CNT_W'(SCREEN_H);
    localparam logic [CNT_W-1:0]  LINE_END_C = CNT_W'(SCREEN_W - 1);
    localparam logic [CNT_W-1:0]  IMG_W_C    = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0]  IMG_H_C    = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0]  X_LAST_C   = CNT_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] STRIDE_C   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_ROW_C = ADDR_W'((IMG_H - 1) * IMG_W);

    state_e            r_state, w_state_nxt;
    cfg_t              r_cfg, w_cfg_in;
    logic [ADDR_W-1:0] r_base_acc;
    logic [CNT_W-1:0]  r_mul_cnt;
    logic              w_latch, w_mul, w_done;
    logic              w_frame_start, w_line_end, w_blank;

    assign w_frame_start = (v_cnt == SH_C) && (h_cnt == '0);
    assign w_line_end    = (h_cnt == LINE_END_C) && (v_cnt < SH_C);
    assign w_blank       = (h_cnt >= SW_C) || (v_cnt >= SH_C);

    always_comb begin
        w_cfg_in            = r_cfg;
        w_cfg_in.scale_log2 = scale_log2;
        w_cfg_in.mode       = mode_e'(mode);
        w_cfg_in.pan_x      = sat_pan(pan_x, IMG_W_C);
        w_cfg_in.pan_y      = sat_pan(pan_y, IMG_H_C);
`ifdef SCALED_ADDR_GEN_MIRROR_EN
        w_cfg_in.mirror     = mirror;
`endif
    end

    // Frame-start row-base FSM: pan_y*IMG_W built by repeated addition.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_frame_start) w_state_nxt = LATCH;
            LATCH:   w_state_nxt = (w_cfg_in.pan_y == '0) ? DONE : MUL;
            MUL:     if (r_mul_cnt == r_cfg.pan_y - CNT_W'(1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_latch  = (r_state == LATCH);
        w_mul    = (r_state == MUL);
        w_done   = (r_state == DONE);
        cfg_busy = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg      <= CFG_RESET;
            r_base_acc <= '0;
            r_mul_cnt  <= '0;
        end else if (w_latch) begin
            r_cfg      <= w_cfg_in;
            r_base_acc <= '0;
            r_mul_cnt  <= '0;
        end else if (w_mul) begin
            r_base_acc <= r_base_acc + STRIDE_C;
            r_mul_cnt  <= r_mul_cnt + CNT_W'(1);
        end
    end

    logic [CNT_W-1:0]  w_x_pos, w_y_pos;
    logic [ADDR_W-1:0] w_x_base_unused, w_y_base;
    logic              w_x_ovf, w_y_ovf;
    logic              w_wrap;

    assign w_wrap = (r_cfg.mode == MODE_WRAP);

    axis_tracker #(.LIMIT(IMG_W), .STRIDE(0), .ADDR_W(ADDR_W)) u_x_trk (
        .clk          (clk),
        .rst          (rst),
        .i_load       (h_cnt == '0),
        .i_load_pos   (r_cfg.pan_x),
        .i_load_base  ('0),
        .i_step       (1'b1),
        .i_scale_log2 (r_cfg.scale_log2),
        .i_wrap       (w_wrap),
        .o_pos        (w_x_pos),
        .o_base       (w_x_base_unused),
        .o_ovf        (w_x_ovf)
    );

    axis_tracker #(.LIMIT(IMG_H), .STRIDE(IMG_W), .ADDR_W(ADDR_W)) u_y_trk (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_done),
        .i_load_pos   (r_cfg.pan_y),
        .i_load_base  (r_base_acc),
        .i_step       (w_line_end),
        .i_scale_log2 (r_cfg.scale_log2),
        .i_wrap       (w_wrap),
        .o_pos        (w_y_pos),
        .o_base       (w_y_base),
        .o_ovf        (w_y_ovf)
    );

    logic [CNT_W-1:0]  w_x_sel, w_x_term;
    logic [ADDR_W-1:0] w_row, w_addr;
    logic              w_in;

    // WRAP never reaches an overflow marker, so the clamp muxes serve CLAMP and WRAP alike.
    always_comb begin
        w_x_sel = w_x_ovf ? X_LAST_C : w_x_pos;
`ifdef SCALED_ADDR_GEN_MIRROR_EN
        w_x_term = r_cfg.mirror ? (X_LAST_C - w_x_sel) : w_x_sel;
`else
        w_x_term = w_x_sel;
`endif
        w_row  = w_y_ovf ? LAST_ROW_C : w_y_base;
        w_addr = w_row + ADDR_W'(w_x_term);
        w_in   = 1'b1;
        if ((r_cfg.mode == MODE_BORDER) && (w_x_ovf || w_y_ovf)) begin
            w_addr = '0;
            w_in   = 1'b0;
        end
    end

    logic [ADDR_W-1:0] r_pixel_addr;
    logic              r_in_image;

    always_ff @(posedge clk) begin
        if (rst || w_blank) begin
            r_pixel_addr <= '0;
            r_in_image   <= 1'b0;
        end else begin
            r_pixel_addr <= w_addr;
            r_in_image   <= w_in;
        end
    end

    assign pixel_addr = r_pixel_addr;
    assign in_image   = r_in_image;

endmodule
